// File: rtl/skeleton_keypoint_detector.sv
// Classifies interior skeleton pixels as endpoints/junctions from a 3x3 raster window and keeps per-frame totals.
// Keypoint appears 2 cycles after the beat that completes its window; no backpressure, gaps via pixel_valid_in.
module skeleton_keypoint_detector #(
   parameter int HORIZONTAL_COUNT = 320,
   parameter int VERTICAL_COUNT   = 180,
   parameter int COUNT_WIDTH      = 8
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic [$clog2(HORIZONTAL_COUNT)-1:0] hcount_in,
   input  logic [$clog2(VERTICAL_COUNT)-1:0]   vcount_in,
   input  logic                                skeleton_in,
   input  logic                                pixel_valid_in,
   output logic                                keypoint_valid_out,
   output logic [$clog2(HORIZONTAL_COUNT)-1:0] keypoint_hcount_out,
   output logic [$clog2(VERTICAL_COUNT)-1:0]   keypoint_vcount_out,
   output logic [1:0]                          keypoint_type_out,
   output logic [COUNT_WIDTH-1:0]              endpoint_count_out,
   output logic [COUNT_WIDTH-1:0]              junction_count_out,
   output logic                                frame_done_out
);
   localparam int HW = $clog2(HORIZONTAL_COUNT);
   localparam int VW = $clog2(VERTICAL_COUNT);
   localparam logic [HW-1:0]          H_LAST  = HW'(HORIZONTAL_COUNT - 1);
   localparam logic [VW-1:0]          V_LAST  = VW'(VERTICAL_COUNT - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   logic [HORIZONTAL_COUNT-1:0] row1_q, row1_d, row2_q, row2_d;
   logic [2:0]                  win_l_q, win_l_d, win_c_q, win_c_d, win_r_q, win_r_d;
   logic                        s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
   logic [HW-1:0]               s1_h_q, s1_h_d, kp_h_q, kp_h_d;
   logic [VW-1:0]               s1_v_q, s1_v_d, kp_v_q, kp_v_d;
   logic                        frame_act_q, frame_act_d;
   logic                        kp_vld_q, kp_vld_d, done_q, done_d;
   logic [1:0]                  kp_type_q, kp_type_d;
   logic [COUNT_WIDTH-1:0]      ep_acc_q, ep_acc_d, jn_acc_q, jn_acc_d;
   logic [COUNT_WIDTH-1:0]      ep_cnt_q, ep_cnt_d, jn_cnt_q, jn_cnt_d;
   logic [COUNT_WIDTH-1:0]      ep_inc, jn_inc;
   logic                        frame_start;
   logic [7:0]                  ring;
   logic [3:0]                  nb_cnt, trans_cnt;
   logic                        is_ep, is_jn;

   assign frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);

   // Window columns are {row v-2, row v-1, row v}; left/centre/right are columns h-2/h-1/h.
   always_comb begin
      row1_d      = row1_q;
      row2_d      = row2_q;
      win_l_d     = win_l_q;
      win_c_d     = win_c_q;
      win_r_d     = win_r_q;
      frame_act_d = frame_act_q || frame_start;
      s1_vld_d    = 1'b0;
      s1_last_d   = 1'b0;
      s1_h_d      = s1_h_q;
      s1_v_d      = s1_v_q;
      if (pixel_valid_in) begin
         win_l_d            = win_c_q;
         win_c_d            = win_r_q;
         win_r_d            = {row2_q[hcount_in], row1_q[hcount_in], skeleton_in};
         row2_d[hcount_in]  = row1_q[hcount_in];
         row1_d[hcount_in]  = skeleton_in;
         s1_vld_d  = frame_act_q && (hcount_in >= HW'(2)) && (vcount_in >= VW'(2));
         s1_last_d = frame_act_q && (hcount_in == H_LAST) && (vcount_in == V_LAST);
         s1_h_d    = hcount_in - HW'(1);
         s1_v_d    = vcount_in - VW'(1);
      end
   end

   // Ring order N,NE,E,SE,S,SW,W,NW from bit 0 upward.
   always_comb begin
      ring      = {win_l_q[2], win_l_q[1], win_l_q[0], win_c_q[0],
                   win_r_q[0], win_r_q[1], win_r_q[2], win_c_q[2]};
      nb_cnt    = '0;
      trans_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         nb_cnt    = nb_cnt + {3'b000, ring[i]};
         trans_cnt = trans_cnt + {3'b000, ~ring[i] & ring[(i + 1) % 8]};
      end
      is_ep = s1_vld_q && win_c_q[1] && (nb_cnt == 4'd1);
      is_jn = s1_vld_q && win_c_q[1] && (trans_cnt >= 4'd3);

      ep_inc = (is_ep && (ep_acc_q != CNT_MAX)) ? ep_acc_q + COUNT_WIDTH'(1) : ep_acc_q;
      jn_inc = (is_jn && (jn_acc_q != CNT_MAX)) ? jn_acc_q + COUNT_WIDTH'(1) : jn_acc_q;
      // A new frame start wins over a keypoint from the previous frame landing on the same edge.
      ep_acc_d = frame_start ? '0 : ep_inc;
      jn_acc_d = frame_start ? '0 : jn_inc;

      kp_vld_d  = is_ep || is_jn;
      kp_h_d    = s1_h_q;
      kp_v_d    = s1_v_q;
      kp_type_d = is_jn ? 2'b10 : 2'b01;
      done_d    = s1_last_q;
      ep_cnt_d  = s1_last_q ? ep_inc : ep_cnt_q;
      jn_cnt_d  = s1_last_q ? jn_inc : jn_cnt_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         row1_q      <= '0;
         row2_q      <= '0;
         win_l_q     <= '0;
         win_c_q     <= '0;
         win_r_q     <= '0;
         frame_act_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_h_q      <= '0;
         s1_v_q      <= '0;
         kp_vld_q    <= 1'b0;
         kp_h_q      <= '0;
         kp_v_q      <= '0;
         kp_type_q   <= '0;
         done_q      <= 1'b0;
         ep_acc_q    <= '0;
         jn_acc_q    <= '0;
         ep_cnt_q    <= '0;
         jn_cnt_q    <= '0;
      end else begin
         row1_q      <= row1_d;
         row2_q      <= row2_d;
         win_l_q     <= win_l_d;
         win_c_q     <= win_c_d;
         win_r_q     <= win_r_d;
         frame_act_q <= frame_act_d;
         s1_vld_q    <= s1_vld_d;
         s1_last_q   <= s1_last_d;
         s1_h_q      <= s1_h_d;
         s1_v_q      <= s1_v_d;
         kp_vld_q    <= kp_vld_d;
         kp_h_q      <= kp_h_d;
         kp_v_q      <= kp_v_d;
         kp_type_q   <= kp_type_d;
         done_q      <= done_d;
         ep_acc_q    <= ep_acc_d;
         jn_acc_q    <= jn_acc_d;
         ep_cnt_q    <= ep_cnt_d;
         jn_cnt_q    <= jn_cnt_d;
      end
   end

   assign keypoint_valid_out  = kp_vld_q;
   assign keypoint_hcount_out = kp_h_q;
   assign keypoint_vcount_out = kp_v_q;
   assign keypoint_type_out   = kp_type_q;
   assign endpoint_count_out  = ep_cnt_q;
   assign junction_count_out  = jn_cnt_q;
   assign frame_done_out      = done_q;

endmodule

// File: tb/tb_skeleton_keypoint_detector.sv
// Bench for skeleton_keypoint_detector on a 10x8 frame; a second instance with 2-bit counters covers saturation.
module tb_skeleton_keypoint_detector;
   localparam int H  = 10;
   localparam int V  = 8;
   localparam int HW = $clog2(H);
   localparam int VW = $clog2(V);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic          skel = 1'b0;
   logic [HW-1:0] hc = '0;
   logic [VW-1:0] vc = '0;

   logic          kv, s_kv, fd, s_fd;
   logic [HW-1:0] kh, s_kh;
   logic [VW-1:0] kvv, s_kvv;
   logic [1:0]    kt, s_kt, s_ep, s_jn;
   logic [7:0]    ep, jn;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   bit img [V][H];
   int bc  [V][H];
   logic [31:0] kp_q[$], exp_kp[$];
   logic [63:0] fd_q[$], exp_fd[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   skeleton_keypoint_detector #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .COUNT_WIDTH(8)) dut (
      .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .skeleton_in(skel),
      .pixel_valid_in(valid), .keypoint_valid_out(kv), .keypoint_hcount_out(kh),
      .keypoint_vcount_out(kvv), .keypoint_type_out(kt), .endpoint_count_out(ep),
      .junction_count_out(jn), .frame_done_out(fd));

   skeleton_keypoint_detector #(.HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .COUNT_WIDTH(2)) dut_sat (
      .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .skeleton_in(skel),
      .pixel_valid_in(valid), .keypoint_valid_out(s_kv), .keypoint_hcount_out(s_kh),
      .keypoint_vcount_out(s_kvv), .keypoint_type_out(s_kt), .endpoint_count_out(s_ep),
      .junction_count_out(s_jn), .frame_done_out(s_fd));

   // Record every observed keypoint / frame-done with the cycle it was seen in.
   always @(negedge clk) begin
      if (kv === 1'b1) kp_q.push_back({3'b000, cyc[19:0], kh, kvv, kt});
      if (fd === 1'b1 || s_fd === 1'b1)
         fd_q.push_back({22'b0, cyc[19:0], fd, ep, jn, s_fd, s_ep, s_jn});
   end

   // Reference classification straight from the neighbourhood definition.
   function automatic logic [1:0] classify(int x, int y);
      int dx[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      int dy[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
      bit r[8];
      int n = 0;
      int a = 0;
      if (!img[y][x]) return 2'b00;
      for (int i = 0; i < 8; i++) r[i] = img[y + dy[i]][x + dx[i]];
      for (int i = 0; i < 8; i++) begin
         n += int'(r[i]);
         if (!r[i] && r[(i + 1) % 8]) a++;
      end
      if (n == 1) return 2'b01;
      if (a >= 3) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_frame();
      int ne = 0;
      int nj = 0;
      logic [1:0] t;
      for (int y = 1; y <= V - 2; y++)
         for (int x = 1; x <= H - 2; x++) begin
            t = classify(x, y);
            if (t != 2'b00) begin
               exp_kp.push_back({3'b000, 20'(bc[y+1][x+1] + 2), HW'(x), VW'(y), t});
               if (t == 2'b01) ne++; else nj++;
            end
         end
      exp_fd.push_back({22'b0, 20'(bc[V-1][H-1] + 2), 1'b1,
                        8'(ne > 255 ? 255 : ne), 8'(nj > 255 ? 255 : nj),
                        1'b1, 2'(ne > 3 ? 3 : ne), 2'(nj > 3 ? 3 : nj)});
   endtask

   // mode 0: continuous, 1: idle cycle before every beat, 2: random gaps.
   task automatic run_frame(int mode, int stop);
      int idx = 0;
      int gaps;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            if (idx < stop) begin
               gaps = (mode == 1) ? 1 :
                      (mode == 2) ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : 0;
               repeat (gaps) begin
                  @(negedge clk);
                  valid = 1'b0;
                  skel  = 1'($urandom_range(0, 1));
               end
               @(negedge clk);
               valid = 1'b1;
               hc    = HW'(x);
               vc    = VW'(y);
               skel  = img[y][x];
               bc[y][x] = cyc;
            end
            idx++;
         end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0;
         skel  = 1'b0;
      end
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_all();
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) img[y][x] = 1'b0;
      kp_q.delete(); exp_kp.delete(); fd_q.delete(); exp_fd.delete();
   endtask

   task automatic set_line();
      for (int x = 2; x <= 5; x++) img[3][x] = 1'b1;
   endtask

   task automatic set_plus();
      for (int k = 2; k <= 6; k++) begin
         img[k][4] = 1'b1;
         img[4][k] = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset(2);
      tests++; if (kv !== 1'b0)    begin fails++; $display("FAIL reset_kp_valid: got %b expected 0", kv); end
      tests++; if (kh !== '0)      begin fails++; $display("FAIL reset_kp_h: got %0d expected 0", kh); end
      tests++; if (kvv !== '0)     begin fails++; $display("FAIL reset_kp_v: got %0d expected 0", kvv); end
      tests++; if (kt !== 2'b00)   begin fails++; $display("FAIL reset_kp_type: got %b expected 00", kt); end
      tests++; if (ep !== 8'd0)    begin fails++; $display("FAIL reset_ep_count: got %0d expected 0", ep); end
      tests++; if (jn !== 8'd0)    begin fails++; $display("FAIL reset_jn_count: got %0d expected 0", jn); end
      tests++; if (fd !== 1'b0)    begin fails++; $display("FAIL reset_frame_done: got %b expected 0", fd); end
      clear_all();
      idle(10);
      tests++; if (kp_q.size() != 0) begin fails++; $display("FAIL reset_idle_kp: got %0d pulses expected 0", kp_q.size()); end
      tests++; if (fd_q.size() != 0) begin fails++; $display("FAIL reset_idle_fd: got %0d pulses expected 0", fd_q.size()); end
   endtask

   task automatic test_line();
      clear_all();
      set_line();
      run_frame(0, H * V);
      model_frame();
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL line_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      for (int i = 0; i < exp_kp.size() && i < kp_q.size(); i++) begin
         tests++; if (kp_q[i] !== exp_kp[i]) begin fails++; $display("FAIL line_kp[%0d]: got %h expected %h", i, kp_q[i], exp_kp[i]); end
      end
      tests++; if (fd_q.size() != 1 || fd_q[0] !== exp_fd[0]) begin fails++; $display("FAIL line_frame_done: got %0d entries first %h expected %h", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : 64'h0, exp_fd[0]); end
      tests++; if (ep !== 8'd2 || jn !== 8'd0) begin fails++; $display("FAIL line_counts_hold: got %0d/%0d expected 2/0", ep, jn); end
   endtask

   task automatic test_plus();
      clear_all();
      set_plus();
      run_frame(0, H * V);
      model_frame();
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL plus_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      for (int i = 0; i < exp_kp.size() && i < kp_q.size(); i++) begin
         tests++; if (kp_q[i] !== exp_kp[i]) begin fails++; $display("FAIL plus_kp[%0d]: got %h expected %h", i, kp_q[i], exp_kp[i]); end
      end
      tests++; if (fd_q.size() != 1 || fd_q[0] !== exp_fd[0]) begin fails++; $display("FAIL plus_frame_done: got %0d entries first %h expected %h", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : 64'h0, exp_fd[0]); end
      tests++; if (ep !== 8'd4 || jn !== 8'd1) begin fails++; $display("FAIL plus_counts: got %0d/%0d expected 4/1", ep, jn); end
   endtask

   task automatic test_gaps();
      clear_all();
      set_plus();
      run_frame(1, H * V);
      model_frame();
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL gaps_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      for (int i = 0; i < exp_kp.size() && i < kp_q.size(); i++) begin
         tests++; if (kp_q[i] !== exp_kp[i]) begin fails++; $display("FAIL gaps_kp[%0d]: got %h expected %h", i, kp_q[i], exp_kp[i]); end
      end
      tests++; if (fd_q.size() != 1 || fd_q[0] !== exp_fd[0]) begin fails++; $display("FAIL gaps_frame_done: got %0d entries first %h expected %h", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : 64'h0, exp_fd[0]); end
      tests++; if (ep !== 8'd4 || jn !== 8'd1) begin fails++; $display("FAIL gaps_counts: got %0d/%0d expected 4/1", ep, jn); end
   endtask

   task automatic test_saturation();
      int sx[5] = '{1, 4, 7, 1, 4};
      int sy[5] = '{1, 1, 1, 4, 4};
      clear_all();
      for (int k = 0; k < 5; k++) begin
         img[sy[k]][sx[k]]         = 1'b1;
         img[sy[k] + 1][sx[k] + 1] = 1'b1;
      end
      run_frame(0, H * V);
      model_frame();
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL sat_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      tests++; if (fd_q.size() != 1 || fd_q[0] !== exp_fd[0]) begin fails++; $display("FAIL sat_frame_done: got %0d entries first %h expected %h", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : 64'h0, exp_fd[0]); end
      tests++; if (s_ep !== 2'd3) begin fails++; $display("FAIL sat_ep_count_w2: got %0d expected 3", s_ep); end
      tests++; if (ep !== 8'd10)  begin fails++; $display("FAIL sat_ep_count_w8: got %0d expected 10", ep); end
   endtask

   task automatic test_reset_midframe();
      clear_all();
      set_line();
      run_frame(0, 4 * H + 6);
      do_reset(1);
      idle(3);
      clear_all();
      tests++; if (ep !== 8'd0 || jn !== 8'd0) begin fails++; $display("FAIL midrst_counts_cleared: got %0d/%0d expected 0/0", ep, jn); end
      idle(8);
      tests++; if (fd_q.size() != 0 || kp_q.size() != 0) begin fails++; $display("FAIL midrst_aborted: got fd=%0d kp=%0d expected 0/0", fd_q.size(), kp_q.size()); end
      set_line();
      run_frame(0, H * V);
      model_frame();
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL midrst_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      for (int i = 0; i < exp_kp.size() && i < kp_q.size(); i++) begin
         tests++; if (kp_q[i] !== exp_kp[i]) begin fails++; $display("FAIL midrst_kp[%0d]: got %h expected %h", i, kp_q[i], exp_kp[i]); end
      end
      tests++; if (fd_q.size() != 1 || fd_q[0] !== exp_fd[0]) begin fails++; $display("FAIL midrst_frame_done: got %0d entries first %h expected %h", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : 64'h0, exp_fd[0]); end
      tests++; if (ep !== 8'd2 || jn !== 8'd0) begin fails++; $display("FAIL midrst_counts: got %0d/%0d expected 2/0", ep, jn); end
   endtask

   // Back-to-back random frames with random gaps; the last keypoint of one frame lands on the next frame's start.
   task automatic test_back_to_back_random();
      clear_all();
      for (int f = 0; f < 4; f++) begin
         for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = ($urandom_range(0, 99) < 35);
         img[V-2][H-2] = 1'b1;
         img[V-1][H-1] = (f % 2 == 0);
         run_frame(2, H * V);
         model_frame();
      end
      idle(8);
      tests++; if (kp_q.size() != exp_kp.size()) begin fails++; $display("FAIL rand_kp_count: got %0d expected %0d", kp_q.size(), exp_kp.size()); end
      for (int i = 0; i < exp_kp.size() && i < kp_q.size(); i++) begin
         tests++; if (kp_q[i] !== exp_kp[i]) begin fails++; $display("FAIL rand_kp[%0d]: got %h expected %h", i, kp_q[i], exp_kp[i]); end
      end
      tests++; if (fd_q.size() != exp_fd.size()) begin fails++; $display("FAIL rand_fd_count: got %0d expected %0d", fd_q.size(), exp_fd.size()); end
      for (int i = 0; i < exp_fd.size() && i < fd_q.size(); i++) begin
         tests++; if (fd_q[i] !== exp_fd[i]) begin fails++; $display("FAIL rand_fd[%0d]: got %h expected %h", i, fd_q[i], exp_fd[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_plus();
      test_gaps();
      test_saturation();
      test_reset_midframe();
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
